// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - packet-locked round-robin merge of NUM_REQ streams into one registered stage
module stream_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ-1:0]       in_last,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [IDX_W-1:0]         out_id,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic             stage_en;
  logic             lock;
  logic [IDX_W-1:0] lock_id;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             has_winner;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  int               idx_int;

  assign stage_en = !out_valid || out_ready;
  assign xfer     = stage_en && has_winner;

  // While locked the owner keeps the grant even through valid bubbles.
  always_comb begin
    winner     = '0;
    has_winner = 1'b0;
    idx_int    = 0;
    cand       = '0;
    if (lock) begin
      winner     = lock_id;
      has_winner = in_valid[lock_id];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx_int = int'(ptr) + k;
        if (idx_int >= NUM_REQ) idx_int = idx_int - NUM_REQ;
        cand = IDX_W'(idx_int);
        if (!has_winner && in_valid[cand]) begin
          has_winner = 1'b1;
          winner     = cand;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_data    = in_data[i*WIDTH +: WIDTH];
        sel_last    = in_last[i];
        in_ready[i] = stage_en && (lock || has_winner);
      end
    end
  end

  always_comb begin
    ptr_next = winner + IDX_W'(1);
    if (winner == IDX_W'(NUM_REQ - 1)) ptr_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      ptr       <= '0;
      lock      <= 1'b0;
      lock_id   <= '0;
    end else if (stage_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_id    <= winner;
        if (sel_last) begin
          lock <= 1'b0;
          ptr  <= ptr_next;
        end else begin
          lock    <= 1'b1;
          lock_id <= winner;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - directed vector bench for stream_rr_arbiter
module tb_stream_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [W-1:0]   out_data;
  logic           out_last, out_valid, out_ready;
  logic [1:0]     out_id;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_last3, in_ready3;
  logic [7:0]  out_data3;
  logic        out_last3, out_valid3, out_ready3;
  logic [1:0]  out_id3;

  stream_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_last(out_last), .out_id(out_id),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_rr_arbiter #(.NUM_REQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
    .in_ready(in_ready3), .out_data(out_data3), .out_last(out_last3), .out_id(out_id3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [3:0]  l;
    logic        ordy;
    logic [7:0]  tag;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  id;
    logic        ol;
    logic [31:0] d;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic ordy, input logic [7:0] tag, input logic [3:0] rdy,
                              input logic ov, input logic [1:0] id, input logic ol,
                              input logic [31:0] d);
    vec_t t;
    t.r = r; t.v = v; t.l = l; t.ordy = ordy; t.tag = tag;
    t.rdy = rdy; t.ov = ov; t.id = id; t.ol = ol; t.d = d;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic apply(input vec_t t, input int n);
    rst       = t.r;
    in_valid  = t.v;
    in_last   = t.l;
    out_ready = t.ordy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = {16'h0, t.tag, 8'(i)};
    #1;
    chk($sformatf("v%0d in_ready", n), 32'(in_ready), 32'(t.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", n), 32'(out_valid), 32'(t.ov));
    if (t.ov) begin
      chk($sformatf("v%0d out_id", n), 32'(out_id), 32'(t.id));
      chk($sformatf("v%0d out_last", n), 32'(out_last), 32'(t.ol));
      chk($sformatf("v%0d out_data", n), out_data, t.d);
    end
  endtask

  task automatic step3(input logic [2:0] v, input logic [2:0] exp_rdy, input logic [1:0] exp_id,
                       input logic [7:0] exp_d, input string nm);
    in_valid3 = v;
    in_last3  = v;
    #1;
    chk({nm, " in_ready3"}, 32'(in_ready3), 32'(exp_rdy));
    @(posedge clk);
    #1;
    chk({nm, " out_valid3"}, 32'(out_valid3), 32'd1);
    chk({nm, " out_id3"}, 32'(out_id3), 32'(exp_id));
    chk({nm, " out_data3"}, 32'(out_data3), 32'(exp_d));
  endtask

  initial begin
    // idle, then all-valid single-beat round robin
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 8'h00, 4'b0000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 8'h01, 4'b0000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 1, 8'h02, 4'b0001, 1, 0, 1, 32'h0200));
    tbl.push_back(mk(0, 4'hF, 4'hF, 1, 8'h03, 4'b0010, 1, 1, 1, 32'h0301));
    tbl.push_back(mk(0, 4'hF, 4'hF, 1, 8'h04, 4'b0100, 1, 2, 1, 32'h0402));
    tbl.push_back(mk(0, 4'hF, 4'hF, 1, 8'h05, 4'b1000, 1, 3, 1, 32'h0503));
    tbl.push_back(mk(0, 4'hF, 4'hF, 1, 8'h06, 4'b0001, 1, 0, 1, 32'h0600));
    // 3-beat packet on requester 2 with a bubble, 0 and 1 still valid
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, 8'h07, 4'b0010, 1, 1, 1, 32'h0701));
    tbl.push_back(mk(0, 4'b0111, 4'b0011, 1, 8'h08, 4'b0100, 1, 2, 0, 32'h0802));
    tbl.push_back(mk(0, 4'b0111, 4'b0011, 1, 8'h09, 4'b0100, 1, 2, 0, 32'h0902));
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 1, 8'h0A, 4'b0100, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 4'b0111, 4'b0111, 1, 8'h0B, 4'b0100, 1, 2, 1, 32'h0B02));
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 1, 8'h0C, 4'b0001, 1, 0, 1, 32'h0C00));
    // backpressure for 3 cycles
    tbl.push_back(mk(0, 4'hF, 4'hF, 1, 8'h0D, 4'b0010, 1, 1, 1, 32'h0D01));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 8'h0E, 4'b0000, 1, 1, 1, 32'h0D01));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 8'h0F, 4'b0000, 1, 1, 1, 32'h0D01));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 4'b0000, 1, 1, 1, 32'h0D01));
    tbl.push_back(mk(0, 4'hF, 4'hF, 1, 8'h11, 4'b0100, 1, 2, 1, 32'h1102));
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 8'h12, 4'b0000, 0, 0, 0, 32'h0));
    // reset in the middle of a packet from requester 1
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'h20, 4'b0010, 1, 1, 0, 32'h2001));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 1, 8'h21, 4'b0010, 1, 1, 0, 32'h2101));
    tbl.push_back(mk(1, 4'b0011, 4'b0000, 1, 8'h22, 4'b0010, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 1, 8'h23, 4'b0001, 1, 0, 1, 32'h2300));
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 1, 8'h24, 4'b0010, 1, 1, 1, 32'h2401));

    rst        = 1'b1;
    in_valid   = '0;
    in_last    = '0;
    in_data    = '0;
    out_ready  = 1'b1;
    in_valid3  = '0;
    in_last3   = '0;
    in_data3   = {8'h32, 8'h31, 8'h30};
    out_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_id", 32'(out_id), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid3", 32'(out_valid3), 32'd0);

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);
    rst = 1'b0;

    // wrap-around on three requesters: move ptr to 2, then 2 wins, then 0
    step3(3'b010, 3'b010, 2'd1, 8'h31, "w0");
    step3(3'b101, 3'b100, 2'd2, 8'h32, "w1");
    step3(3'b101, 3'b001, 2'd0, 8'h30, "w2");
    step3(3'b101, 3'b100, 2'd2, 8'h32, "w3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
